// File: rtl/ro_puf_response.sv
// Ring-oscillator PUF response generator: synchronizes two challenge-selected
// oscillators, counts their rising edges over a fixed window and reports A > B.
module ro_puf_response #(
  parameter int NUM_RO = 16,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 4,
  localparam int SEL_W = $clog2(NUM_RO)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_RO-1:0]  ro_in,
  input  logic               start,
  input  logic [2*SEL_W-1:0] challenge,
  output logic               ready,
  output logic               resp_valid,
  output logic               resp_bit,
  output logic               resp_tie,
  output logic               resp_sat,
  output logic               resp_err,
  output logic [CNT_W-1:0]   count_a,
  output logic [CNT_W-1:0]   count_b
);

  localparam int SEL_N   = 2 ** SEL_W;
  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [SEL_N-1:0] SEL_VALID = {SEL_N{1'b1}} >> (SEL_N - NUM_RO);

  // ACCEPT is the decision cycle between taking a challenge and either
  // reporting an error or starting the settle period.
  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_SETTLE, S_COUNT, S_COMPARE, S_REPORT
  } state_t;

  state_t             state;
  logic [NUM_RO-1:0]  sync1, sync2, sync3;
  logic [SEL_N-1:0]   edges;
  logic [SEL_W-1:0]   sel_a, sel_b;
  logic [TMR_W-1:0]   timer;
  logic               sat_a, sat_b;
  logic               legal;

  assign edges = SEL_N'(sync2 & ~sync3);
  assign legal = SEL_VALID[sel_a] & SEL_VALID[sel_b] & (sel_a != sel_b);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      sync1      <= '0;
      sync2      <= '0;
      sync3      <= '0;
      sel_a      <= '0;
      sel_b      <= '0;
      timer      <= '0;
      sat_a      <= 1'b0;
      sat_b      <= 1'b0;
      ready      <= 1'b1;
      resp_valid <= 1'b0;
      resp_bit   <= 1'b0;
      resp_tie   <= 1'b0;
      resp_sat   <= 1'b0;
      resp_err   <= 1'b0;
      count_a    <= '0;
      count_b    <= '0;
    end else begin
      sync1      <= ro_in;
      sync2      <= sync1;
      sync3      <= sync2;
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sel_a    <= challenge[SEL_W-1:0];
            sel_b    <= challenge[2*SEL_W-1:SEL_W];
            ready    <= 1'b0;
            count_a  <= '0;
            count_b  <= '0;
            sat_a    <= 1'b0;
            sat_b    <= 1'b0;
            resp_bit <= 1'b0;
            resp_tie <= 1'b0;
            resp_sat <= 1'b0;
            resp_err <= 1'b0;
            state    <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (!legal) begin
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= S_REPORT;
          end else begin
            timer <= TMR_W'(SETTLE - 1);
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (timer == '0) begin
            timer <= TMR_W'(WINDOW - 1);
            state <= S_COUNT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_COUNT: begin
          // Sticky saturation: once a counter reaches its ceiling it stays there.
          if (edges[sel_a] && count_a != CNT_MAX) begin
            count_a <= count_a + 1'b1;
            if (count_a == CNT_MAX - 1'b1) sat_a <= 1'b1;
          end
          if (edges[sel_b] && count_b != CNT_MAX) begin
            count_b <= count_b + 1'b1;
            if (count_b == CNT_MAX - 1'b1) sat_b <= 1'b1;
          end
          if (timer == '0) begin
            state <= S_COMPARE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_COMPARE: begin
          resp_bit   <= count_a > count_b;
          resp_tie   <= count_a == count_b;
          resp_sat   <= sat_a | sat_b;
          resp_valid <= 1'b1;
          state      <= S_REPORT;
        end
        S_REPORT: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_response.sv
// Randomized bench for ro_puf_response: a default-sized instance plus a small
// saturating instance, both checked against an edge-counting reference model.
module tb_ro_puf_response;

  localparam int NUM_RO   = 16;
  localparam int SEL_W    = 4;
  localparam int CNT_W    = 16;
  localparam int WINDOW   = 1024;
  localparam int SETTLE   = 4;
  localparam int S_CNT_W  = 4;
  localparam int S_WINDOW = 64;
  localparam int RW       = 4 + 2 * CNT_W;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NUM_RO-1:0]  ro_in;
  logic               start, ready, resp_valid, resp_bit, resp_tie, resp_sat, resp_err;
  logic [2*SEL_W-1:0] challenge;
  logic [CNT_W-1:0]   count_a, count_b;

  logic               start2, ready2, resp_valid2, resp_bit2, resp_tie2, resp_sat2, resp_err2;
  logic [2*SEL_W-1:0] challenge2;
  logic [S_CNT_W-1:0] count_a2, count_b2;

  ro_puf_response #(.NUM_RO(NUM_RO), .CNT_W(CNT_W), .WINDOW(WINDOW), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .ro_in(ro_in), .start(start), .challenge(challenge),
    .ready(ready), .resp_valid(resp_valid), .resp_bit(resp_bit), .resp_tie(resp_tie),
    .resp_sat(resp_sat), .resp_err(resp_err), .count_a(count_a), .count_b(count_b)
  );

  ro_puf_response #(.NUM_RO(NUM_RO), .CNT_W(S_CNT_W), .WINDOW(S_WINDOW), .SETTLE(SETTLE)) dut_sat (
    .clk(clk), .reset_n(reset_n), .ro_in(ro_in), .start(start2), .challenge(challenge2),
    .ready(ready2), .resp_valid(resp_valid2), .resp_bit(resp_bit2), .resp_tie(resp_tie2),
    .resp_sat(resp_sat2), .resp_err(resp_err2), .count_a(count_a2), .count_b(count_b2)
  );

  // Oscillators: square waves with half-period hp[i] and phase ph[i] in clk
  // cycles, changing on the falling edge so every rising edge samples cleanly.
  int hp[NUM_RO] = '{default: 7};
  int ph[NUM_RO] = '{default: 0};
  int tneg = 0;
  always @(negedge clk) begin
    tneg++;
    for (int i = 0; i < NUM_RO; i++) ro_in[i] = (((tneg + ph[i]) / hp[i]) % 2) != 0;
  end

  // Value of ro_in seen at every rising clock edge; index = edge number.
  logic [NUM_RO-1:0] hist[$];
  always @(posedge clk) hist.push_back(ro_in);

  int nvalid = 0;
  always @(negedge clk) if (resp_valid) nvalid++;

  // scoreboard
  logic [RW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: rising edges of oscillator ch first sampled at edges lo..hi.
  // A sample taken at edge k reaches the edge detector two edges later, so a
  // window counting at edges E0+SETTLE+2 .. E0+SETTLE+WINDOW+1 covers k = lo..hi.
  function automatic int rises(input int ch, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++)
      if (hist[k][ch] === 1'b1 && hist[k-1][ch] === 1'b0) n++;
    return n;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", 0, 1);
  endtask

  // driver: one challenge on the main instance, optional ignored start pulses
  task automatic run_chal(input logic [3:0] a, input logic [3:0] b, input bit busy,
                          input bit one_check);
    int e0, ev, n, nv0, ra, rb, ca, cb;
    logic [RW-1:0] er;
    wait_ready();
    nv0 = nvalid;
    start = 1'b1;
    challenge = {b, a};
    @(posedge clk);
    #1;
    e0 = hist.size() - 1;
    start = 1'b0;
    challenge = 8'($urandom);
    check("ready_low", ready, 0);
    check("cnt_clear", {count_a, count_b}, 0);
    if (busy) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      challenge = {a, b};
      @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      start = 1'b1;
      challenge = ~{b, a};
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (resp_valid !== 1'b1 && n < SETTLE + WINDOW + 50) begin
      @(negedge clk);
      n++;
    end
    if (resp_valid !== 1'b1) begin
      check("resp_timeout", 0, 1);
      return;
    end
    ev = hist.size() - 1;
    if (a != b) begin
      check("latency", ev - e0, SETTLE + WINDOW + 2);
      ra = rises(a, e0 + SETTLE, e0 + SETTLE + WINDOW - 1);
      rb = rises(b, e0 + SETTLE, e0 + SETTLE + WINDOW - 1);
      ca = (ra > 65535) ? 65535 : ra;
      cb = (rb > 65535) ? 65535 : rb;
      exp_q.push_back({1'b0, (ra >= 65535 || rb >= 65535), (ca == cb), (ca > cb),
                       16'(ca), 16'(cb)});
    end else begin
      check("err_latency", ev - e0, 1);
      exp_q.push_back('0 | (RW'(1) << (RW - 1)));
    end
    er = exp_q.pop_front();
    check("resp_err", resp_err, er[RW-1]);
    check("resp_sat", resp_sat, er[RW-2]);
    check("resp_tie", resp_tie, er[RW-3]);
    check("resp_bit", resp_bit, er[RW-4]);
    check("count_a", count_a, er[2*CNT_W-1:CNT_W]);
    check("count_b", count_b, er[CNT_W-1:0]);
    if (one_check) begin
      repeat (3) @(negedge clk);
      check("one_valid", nvalid - nv0, 1);
    end
  endtask

  initial begin
    int e0, ev, n, nv0, ra, rb, diffs;
    logic [4+2*CNT_W:0] snap;
    logic [3:0] a, b;
    reset_n = 1'b0;
    start = 1'b0;
    challenge = '0;
    start2 = 1'b0;
    challenge2 = '0;
    repeat (4) @(negedge clk);
    check("rst_ready", {ready, ready2}, 2'b11);
    check("rst_resp", {resp_valid, resp_bit, resp_tie, resp_sat, resp_err}, 0);
    check("rst_counts", {count_a, count_b}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic response: period 4 vs period 8, then swapped
    hp[2] = 2;
    hp[5] = 4;
    run_chal(4'd2, 4'd5, 1'b0, 1'b1);
    check("basic_a_256", (count_a >= 255 && count_a <= 257), 1);
    check("basic_b_128", (count_b >= 127 && count_b <= 129), 1);
    run_chal(4'd5, 4'd2, 1'b0, 1'b1);
    check("swap_bit0", resp_bit, 0);

    // phase-aligned equal periods, then an illegal challenge
    hp[3] = 4;
    hp[4] = 4;
    ph[3] = 5;
    ph[4] = 5;
    run_chal(4'd3, 4'd4, 1'b0, 1'b1);
    check("tie_count", count_a, 128);
    run_chal(4'd7, 4'd7, 1'b0, 1'b1);

    // ignored starts while busy, then back-to-back acceptance
    run_chal(4'd2, 4'd5, 1'b1, 1'b1);
    run_chal(4'd5, 4'd2, 1'b0, 1'b0);
    run_chal(4'd2, 4'd5, 1'b0, 1'b1);

    // random oscillator mixes and challenges
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < NUM_RO; i++) begin
        hp[i] = $urandom_range(1, 12);
        ph[i] = $urandom_range(0, 23);
      end
      a = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 4) == 0) ? a : 4'($urandom_range(0, 15));
      run_chal(a, b, 1'b0, 1'b1);
    end

    // reset midway through COUNT
    hp[2] = 2;
    hp[5] = 4;
    wait_ready();
    nv0 = nvalid;
    start = 1'b1;
    challenge = {4'd5, 4'd2};
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (500) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready", ready, 1);
    check("abort_resp", {resp_valid, resp_bit, resp_tie, resp_sat, resp_err}, 0);
    check("abort_counts", {count_a, count_b}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (1200) @(negedge clk);
    check("abort_novalid", nvalid - nv0, 0);

    // idle stability with every oscillator toggling
    run_chal(4'd2, 4'd5, 1'b0, 1'b1);
    for (int i = 0; i < NUM_RO; i++) hp[i] = $urandom_range(1, 9);
    snap = {ready, resp_bit, resp_tie, resp_sat, resp_err, count_a, count_b};
    nv0 = nvalid;
    diffs = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ({ready, resp_bit, resp_tie, resp_sat, resp_err, count_a, count_b} !== snap) diffs++;
    end
    check("idle_hold", diffs, 0);
    check("idle_novalid", nvalid - nv0, 0);

    // saturation on the 4-bit / 64-cycle instance
    hp[0] = 1;
    ph[0] = 0;
    hp[1] = 20;
    n = 0;
    while (ready2 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    start2 = 1'b1;
    challenge2 = {4'd1, 4'd0};
    @(posedge clk);
    #1;
    e0 = hist.size() - 1;
    start2 = 1'b0;
    n = 0;
    while (resp_valid2 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (resp_valid2 !== 1'b1) begin
      check("sat_timeout", 0, 1);
    end else begin
      ev = hist.size() - 1;
      ra = rises(0, e0 + SETTLE, e0 + SETTLE + S_WINDOW - 1);
      rb = rises(1, e0 + SETTLE, e0 + SETTLE + S_WINDOW - 1);
      check("sat_latency", ev - e0, SETTLE + S_WINDOW + 2);
      check("sat_count_a", count_a2, (ra > 15) ? 15 : ra);
      check("sat_count_a15", count_a2, 15);
      check("sat_count_b", count_b2, (rb > 15) ? 15 : rb);
      check("sat_flag", resp_sat2, (ra >= 15 || rb >= 15));
      check("sat_bit", resp_bit2, (((ra > 15) ? 15 : ra) > ((rb > 15) ? 15 : rb)));
      repeat (20) @(negedge clk);
      check("sat_hold15", count_a2, 15);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ro_puf_response.md
# ro_puf_response

Response generator for the ring-oscillator PUF; it sits directly downstream of the 16-oscillator array. It accepts a challenge that selects two oscillators and synchronizes their free-running outputs into the `clk` domain. It then counts rising edges of each over a fixed measurement window and emits a one-bit response: oscillator A faster than oscillator B. Raw counts and tie, saturation and error flags are exported for characterization and helper-data logic.

## Interface
Parameters:
- `NUM_RO`, default 16: number of oscillator inputs; selector width is `SEL_W = $clog2(NUM_RO)`.
- `CNT_W`, default 16: edge-counter width.
- `WINDOW`, default 1024: measurement window, in `clk` cycles; must be ≥ 1.
- `SETTLE`, default 4: synchronizer flush cycles before counting; must be ≥ 3.

Ports:
- `clk` input 1: single system clock; every flop in the block is on its rising edge.
- `reset_n` input 1: reset, synchronous and active-low.
- `ro_in` input `NUM_RO`: asynchronous oscillator outputs from the RO array.
- `start` input 1: challenge request; accepted only while `ready`=1.
- `challenge` input `2*SEL_W`: `[SEL_W-1:0]` is sel_a and `[2*SEL_W-1:SEL_W]` is sel_b; sampled with an accepted `start`.
- `ready` output 1: block idle and able to accept `start`.
- `resp_valid` output 1: one-cycle pulse; all `resp_*` outputs are valid in that cycle.
- `resp_bit` output 1: 1 iff count_a > count_b.
- `resp_tie` output 1: count_a == count_b.
- `resp_sat` output 1: either counter saturated during the window.
- `resp_err` output 1: illegal challenge (sel_a == sel_b, or either index ≥ `NUM_RO`).
- `count_a` output `CNT_W`: final edge count of oscillator A.
- `count_b` output `CNT_W`: final edge count of oscillator B.

## Operation
- **Synchronization**
  - Every `ro_in[i]` passes through a 2-flop synchronizer.
  - A third flop provides rising-edge detect: `edge_i = s2 & ~s3`.
  - The synchronizers run continuously, in all states.
- **FSM states**
  - IDLE: `ready`=1. On `start`, latch sel_a and sel_b.
    - If the challenge is illegal, go to REPORT with `resp_err`=1.
    - Otherwise clear both counters and go to SETTLE.
  - SETTLE: run `SETTLE` cycles with the counters held at 0, then go to COUNT.
  - COUNT: run exactly `WINDOW` cycles.
    - Each cycle, count_a += `edge[sel_a]` and count_b += `edge[sel_b]`.
    - Each counter saturates at 2^`CNT_W`−1 and sets a sticky sat flag.
    - After the last cycle, go to COMPARE.
  - COMPARE: one cycle; register `resp_bit`, `resp_tie` and `resp_sat` (sat_a | sat_b). Go to REPORT.
  - REPORT: one cycle; `resp_valid`=1. Go to IDLE.
- **Compare arithmetic**: unsigned, `CNT_W` bits. A tie gives `resp_bit`=0 and `resp_tie`=1.
- **Error path**: `resp_bit`, `resp_tie` and `resp_sat` are 0, and `count_a`/`count_b` are 0.
- **Holding**: `resp_*` and `count_*` hold their values after REPORT until the next accepted `start`. The counters clear on acceptance.
- **Start while not IDLE**: ignored. The challenge is not latched and no queueing occurs.
- **Reset mid-operation**: abort and return to IDLE; all state clears. No `resp_valid` is produced for the aborted challenge.
- **Reset values**
  - `ready`=1.
  - `resp_valid`, `resp_bit`, `resp_tie`, `resp_sat` and `resp_err` = 0.
  - `count_a` and `count_b` = 0.
  - The synchronizer flops also reset to 0.

## Timing
- The edge where `start` is accepted is E0.
  - `ready` is low from E0+1 until REPORT exits.
  - SETTLE occupies the cycles after edges E0+1 … E0+`SETTLE`.
  - COUNT occupies the `WINDOW` cycles that follow.
  - `resp_valid` is high for the cycle after edge E0+`SETTLE`+`WINDOW`+2.
  - `ready` returns to 1 on the following edge.
- Total latency with defaults: 1030 edges from acceptance to `resp_valid`.
- Error-path latency: `resp_valid` is high in the cycle after edge E0+1.
- Back-to-back operation: `start` may be asserted in the first cycle `ready` is back at 1.
- Edge counts are exact for `ro_in` transitions slower than `clk`/2. Faster oscillators alias; this is acceptable PUF behaviour, and repeatability, not frequency accuracy, is the requirement.

## Test plan
- **Basic response**: after reset, drive `ro_in[2]` with a period of 4 clk and `ro_in[5]` with a period of 8 clk; `start`, challenge = {4'd5, 4'd2} → `resp_valid` 1030 edges later; `count_a` = 256±1, `count_b` = 128±1, `resp_bit`=1, `resp_tie`=0. Swapped challenge → `resp_bit`=0.
- **Tie and error**:
  - Equal periods (8 and 8), phase-aligned → `count_a` = `count_b` = 128, `resp_tie`=1, `resp_bit`=0.
  - Challenge {4'd7, 4'd7} → `resp_valid` in the cycle after E0+1 with `resp_err`=1 and counts 0.
- **Saturation**: `CNT_W`=4, `WINDOW`=64, `ro_in[0]` with period 2 → `count_a`=15, `resp_sat`=1, and the count holds at 15 without wrapping.
- **Busy and back-to-back**:
  - `start` pulses during SETTLE and COUNT → ignored; exactly one `resp_valid` results, and the latched challenge is unchanged.
  - A new `start` in the first cycle `ready`=1 → accepted, and the counters clear.
- **Reset mid-operation**: assert `reset_n`=0 for one cycle midway through COUNT → next edge shows `ready`=1 with all `resp_*` and `count_*` at 0, and no `resp_valid` ever appears for the aborted challenge.
- **Idle stability**: outputs hold the last response unchanged for 2000 idle cycles while all `ro_in` toggle.
